// File: rtl/rotating_banner_ctrl.sv
// rotating_banner_ctrl
//
// Drives a time-multiplexed, active-low seven-segment display of NUM_DIGITS
// digits. The display shows a NUM_DIGITS-wide window into a MSG_LEN-symbol
// message that the host can rewrite at runtime. The window rotates left or
// right once every 2**TICK_W enabled, unpaused cycles. Each digit is strobed
// for 2**REFRESH_W cycles.
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   en_i        1 = display on; 0 = anodes off, rotation frozen
//   dir_i       0 = rotate left (pos increments), 1 = rotate right
//   pause_i     1 = freeze rotation, scanning continues
//   msg_we_i    message write strobe
//   msg_addr_i  message write index (indices >= MSG_LEN are ignored)
//   msg_data_i  [4] = blank flag, [3:0] = hex symbol
//   an_o        active-low one-hot anode select
//   sseg_o      active-low segments {g,f,e,d,c,b,a}
//   dp_o        active-low decimal point, marks message index 0
//   pos_o       current window start index
module rotating_banner_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 10,
    parameter int TICK_W     = 12,
    parameter int REFRESH_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  dir_i,
    input  logic                  pause_i,
    input  logic                  msg_we_i,
    input  logic [3:0]            msg_addr_i,
    input  logic [4:0]            msg_data_i,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [6:0]            sseg_o,
    output logic                  dp_o,
    output logic [3:0]            pos_o
);

    localparam logic [3:0] LAST_POS   = 4'(MSG_LEN - 1);
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [4:0] MSG_LEN_W  = 5'(MSG_LEN);

    // Window start after one rotation step in the requested direction.
    function automatic logic [3:0] next_pos(input logic [3:0] pos, input logic dir);
        if (!dir) begin
            return (pos == LAST_POS) ? 4'd0 : pos + 4'd1;
        end
        return (pos == 4'd0) ? LAST_POS : pos - 4'd1;
    endfunction

    // The raw index sum never reaches 2*MSG_LEN, so a single conditional
    // subtract is a complete modulo.
    function automatic logic [3:0] wrap_index(input logic [4:0] sum);
        if (sum >= MSG_LEN_W) begin
            return 4'(sum - MSG_LEN_W);
        end
        return sum[3:0];
    endfunction

    // Active-low hex decode; bit 4 of the symbol blanks the digit.
    function automatic logic [6:0] seg_decode(input logic [4:0] sym);
        if (sym[4]) begin
            return 7'h7F;
        end
        case (sym[3:0])
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    logic [TICK_W-1:0]     tick_cnt_p0;
    logic [REFRESH_W-1:0]  refresh_cnt_p0;
    logic [2:0]            scan_idx_p0;
    logic [3:0]            pos_p0;
    logic [4:0]            msg_p0 [MSG_LEN];
    logic                  vld_p0;
    logic                  rot_run_p0;
    logic [4:0]            sum_p0;
    logic [3:0]            idx_p0;
    logic [4:0]            sym_p0;
    logic [NUM_DIGITS-1:0] an_nxt_p0;

    logic [NUM_DIGITS-1:0] an_p1;
    logic [6:0]            sseg_p1;
    logic                  dp_p1;

    assign vld_p0     = en_i;
    assign rot_run_p0 = en_i && !pause_i;

    // Stage p0: prescalers, window position, scan index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_p0    <= '0;
            refresh_cnt_p0 <= '0;
            scan_idx_p0    <= '0;
            pos_p0         <= '0;
        end else begin
            refresh_cnt_p0 <= refresh_cnt_p0 + 1'b1;
            if (&refresh_cnt_p0) begin
                scan_idx_p0 <= (scan_idx_p0 == LAST_DIGIT) ? 3'd0 : scan_idx_p0 + 3'd1;
            end
            if (rot_run_p0) begin
                tick_cnt_p0 <= tick_cnt_p0 + 1'b1;
                if (&tick_cnt_p0) begin
                    pos_p0 <= next_pos(pos_p0, dir_i);
                end
            end
        end
    end

    // Message store. Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_p0[i] <= {1'b0, 4'(i)};
            end
        end else begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if (msg_we_i && (msg_addr_i == 4'(i))) begin
                    msg_p0[i] <= msg_data_i;
                end
            end
        end
    end

    // Digit k shows message index (pos + NUM_DIGITS-1-k) mod MSG_LEN.
    always_comb begin
        sum_p0 = {1'b0, pos_p0} + {2'b00, LAST_DIGIT - scan_idx_p0};
        idx_p0 = wrap_index(sum_p0);
        sym_p0 = 5'h10;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (idx_p0 == 4'(i)) begin
                sym_p0 = msg_p0[i];
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt_p0[i] = (scan_idx_p0 != 3'(i));
        end
    end

    // Stage p1: registered display drive
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_p1   <= '1;
            sseg_p1 <= 7'h7F;
            dp_p1   <= 1'b1;
        end else if (!vld_p0) begin
            an_p1   <= '1;
            sseg_p1 <= 7'h7F;
            dp_p1   <= 1'b1;
        end else begin
            an_p1   <= an_nxt_p0;
            sseg_p1 <= seg_decode(sym_p0);
            dp_p1   <= (idx_p0 != 4'd0);
        end
    end

    assign an_o   = an_p1;
    assign sseg_o = sseg_p1;
    assign dp_o   = dp_p1;
    assign pos_o  = pos_p0;

endmodule

// File: tb/tb_rotating_banner_ctrl.sv
module tb_rotating_banner_ctrl;

    logic       clk;
    logic       rst_ni;
    logic       en_i;
    logic       dir_i;
    logic       pause_i;
    logic       msg_we_i;
    logic [3:0] msg_addr_i;
    logic [4:0] msg_data_i;
    logic [3:0] an_o;
    logic [6:0] sseg_o;
    logic       dp_o;
    logic [3:0] pos_o;

    int n_cmp = 0;
    int n_bad = 0;

    rotating_banner_ctrl #(
        .NUM_DIGITS(4),
        .MSG_LEN   (6),
        .TICK_W    (4),
        .REFRESH_W (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .dir_i     (dir_i),
        .pause_i   (pause_i),
        .msg_we_i  (msg_we_i),
        .msg_addr_i(msg_addr_i),
        .msg_data_i(msg_data_i),
        .an_o      (an_o),
        .sseg_o    (sseg_o),
        .dp_o      (dp_o),
        .pos_o     (pos_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ncyc;
        logic       en;
        logic       pause;
        logic       dir;
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
        logic [3:0] pos;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for digit k to be strobed, then check its segments.
    task automatic check_digit(input int k, input logic [6:0] exp_seg, input logic exp_dp,
                               input string name);
        logic [3:0] want_an;
        bit         found;
        want_an = ~(4'b0001 << k);
        found   = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk);
            if (an_o == want_an) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: digit %0d never strobed, an_o=%b", name, k, an_o);
        end else begin
            check({name, "_sseg"}, 32'(sseg_o), 32'(exp_seg));
            check({name, "_dp"}, 32'(dp_o), 32'(exp_dp));
        end
    endtask

    task automatic write_msg(input logic [3:0] addr, input logic [4:0] data);
        msg_we_i   = 1'b1;
        msg_addr_i = addr;
        msg_data_i = data;
        @(negedge clk);
        msg_we_i   = 1'b0;
    endtask

    initial begin
        bit done;

        //          ncyc en    pause dir   an       sseg        dp    pos
        vecs[0]  = '{1,  1'b1, 1'b1, 1'b0, 4'b1110, 7'b0110000, 1'b1, 4'd0};
        vecs[1]  = '{3,  1'b1, 1'b1, 1'b0, 4'b1110, 7'b0110000, 1'b1, 4'd0};
        vecs[2]  = '{1,  1'b1, 1'b1, 1'b0, 4'b1101, 7'b0100100, 1'b1, 4'd0};
        vecs[3]  = '{4,  1'b1, 1'b1, 1'b0, 4'b1011, 7'b1111001, 1'b1, 4'd0};
        vecs[4]  = '{4,  1'b1, 1'b1, 1'b0, 4'b0111, 7'b1000000, 1'b0, 4'd0};
        vecs[5]  = '{3,  1'b1, 1'b1, 1'b0, 4'b0111, 7'b1000000, 1'b0, 4'd0};
        vecs[6]  = '{1,  1'b1, 1'b1, 1'b0, 4'b1110, 7'b0110000, 1'b1, 4'd0};
        vecs[7]  = '{16, 1'b1, 1'b0, 1'b0, 4'b1110, 7'b0110000, 1'b1, 4'd1};
        vecs[8]  = '{12, 1'b1, 1'b0, 1'b0, 4'b0111, 7'b1111001, 1'b1, 4'd1};
        vecs[9]  = '{52, 1'b1, 1'b0, 1'b0, 4'b1110, 7'b1111001, 1'b1, 4'd5};
        vecs[10] = '{16, 1'b1, 1'b0, 1'b0, 4'b1110, 7'b0100100, 1'b1, 4'd0};
        vecs[11] = '{16, 1'b1, 1'b0, 1'b1, 4'b1110, 7'b0110000, 1'b1, 4'd5};
        vecs[12] = '{8,  1'b1, 1'b0, 1'b1, 4'b1011, 7'b1000000, 1'b0, 4'd5};
        vecs[13] = '{4,  1'b1, 1'b0, 1'b1, 4'b0111, 7'b0010010, 1'b1, 4'd5};

        rst_ni     = 1'b0;
        en_i       = 1'b1;
        pause_i    = 1'b1;
        dir_i      = 1'b0;
        msg_we_i   = 1'b0;
        msg_addr_i = 4'd0;
        msg_data_i = 5'd0;

        repeat (3) @(negedge clk);
        check("rst_an", 32'(an_o), 32'hF);
        check("rst_sseg", 32'(sseg_o), 32'h7F);
        check("rst_dp", 32'(dp_o), 32'h1);
        check("rst_pos", 32'(pos_o), 32'h0);
        rst_ni = 1'b1;

        // Table-driven scan and rotation sequence
        for (int v = 0; v < 14; v++) begin
            en_i    = vecs[v].en;
            pause_i = vecs[v].pause;
            dir_i   = vecs[v].dir;
            repeat (vecs[v].ncyc) @(negedge clk);
            check($sformatf("vec%0d_an", v), 32'(an_o), 32'(vecs[v].an));
            check($sformatf("vec%0d_sseg", v), 32'(sseg_o), 32'(vecs[v].sseg));
            check($sformatf("vec%0d_dp", v), 32'(dp_o), 32'(vecs[v].dp));
            check($sformatf("vec%0d_pos", v), 32'(pos_o), 32'(vecs[v].pos));
        end

        // Message writes at pos 5 (window 5,0,1,2)
        pause_i = 1'b1;
        write_msg(4'd2, 5'h0A);
        write_msg(4'd3, 5'h10);
        repeat (17) @(negedge clk);
        check_digit(0, 7'b0001000, 1'b1, "wr_idx2");
        check_digit(3, 7'b0010010, 1'b1, "wr_idx5");
        check_digit(2, 7'b1000000, 1'b0, "wr_idx0");

        // One left step to pos 0 (window 0,1,2,3)
        dir_i   = 1'b0;
        pause_i = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (pos_o != 4'd5) done = 1'b1;
        end
        pause_i = 1'b1;
        check("step_to_0", 32'(pos_o), 32'h0);
        check_digit(0, 7'h7F, 1'b1, "blank_idx3");
        check_digit(1, 7'b0001000, 1'b1, "win_idx2");

        // Out-of-range writes must not disturb anything
        write_msg(4'd7, 5'h01);
        write_msg(4'd6, 5'h01);
        repeat (17) @(negedge clk);
        check_digit(3, 7'b1000000, 1'b0, "oor_idx0");
        check_digit(2, 7'b1111001, 1'b1, "oor_idx1");
        check_digit(1, 7'b0001000, 1'b1, "oor_idx2");
        check_digit(0, 7'h7F, 1'b1, "oor_idx3");
        check("oor_pos", 32'(pos_o), 32'h0);

        // Enable off holds the rotation prescaler mid-period
        pause_i = 1'b0;
        repeat (5) @(negedge clk);
        check("en_pre_pos", 32'(pos_o), 32'h0);
        en_i = 1'b0;
        @(negedge clk);
        check("en_off_an", 32'(an_o), 32'hF);
        check("en_off_sseg", 32'(sseg_o), 32'h7F);
        check("en_off_dp", 32'(dp_o), 32'h1);
        repeat (39) @(negedge clk);
        check("en_off_an40", 32'(an_o), 32'hF);
        check("en_off_pos40", 32'(pos_o), 32'h0);
        en_i = 1'b1;
        repeat (10) @(negedge clk);
        check("en_resume_hold", 32'(pos_o), 32'h0);
        @(negedge clk);
        check("en_resume_step", 32'(pos_o), 32'h1);

        // Rotate to pos 4, then asynchronous reset between clock edges
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (pos_o == 4'd4) done = 1'b1;
        end
        check("reach_pos4", 32'(pos_o), 32'h4);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_an", 32'(an_o), 32'hF);
        check("async_rst_sseg", 32'(sseg_o), 32'h7F);
        check("async_rst_dp", 32'(dp_o), 32'h1);
        check("async_rst_pos", 32'(pos_o), 32'h0);
        @(negedge clk);
        pause_i = 1'b1;
        rst_ni  = 1'b1;
        check_digit(0, 7'b0110000, 1'b1, "post_rst_idx3");
        check_digit(1, 7'b0100100, 1'b1, "post_rst_idx2");
        check_digit(2, 7'b1111001, 1'b1, "post_rst_idx1");
        check_digit(3, 7'b1000000, 1'b0, "post_rst_idx0");
        check("post_rst_pos", 32'(pos_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rotating_banner_ctrl.md
Name: rotating_banner_ctrl

Overview:
Parametrised successor to the fixed 4-digit rotating LED banner. It drives a time-multiplexed, active-low seven-segment display of NUM_DIGITS digits and shows a window of a runtime-writable message of MSG_LEN symbols. The window rotates left or right at a rate set by a prescaler, with pause and enable control. It sits between board-level seven-segment pins and a host or user-logic write port.

Parameters:
NUM_DIGITS, 4, number of physical digits (2..8)
MSG_LEN, 10, message symbols; must be >= NUM_DIGITS and <= 16
TICK_W, 12, rotation prescaler width; one rotation step every 2**TICK_W cycles
REFRESH_W, 8, scan prescaler width; each digit is active for 2**REFRESH_W cycles

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  1 = display on; 0 = all anodes off and rotation frozen
dir_i  in  1  0 = rotate left (pos increments), 1 = rotate right (pos decrements)
pause_i  in  1  1 = freeze rotation; scanning continues
msg_we_i  in  1  message write strobe
msg_addr_i  in  4  message write index
msg_data_i  in  5  [4] = blank flag, [3:0] = hex symbol
an_o  out  NUM_DIGITS  active-low one-hot anode select
sseg_o  out  7  active-low segments, [6:0] = g,f,e,d,c,b,a
dp_o  out  1  active-low decimal point
pos_o  out  4  current window start index

Behaviour:
- One clock domain, clk_i. Reset is asynchronous and active-low on rst_ni. All state is asynchronously cleared when rst_ni=0.
- Reset values: an_o = all 1s, sseg_o = 7'h7F, dp_o = 1, pos_o = 0, scan index = 0, both prescalers = 0. Message entry i = {1'b0, i[3:0]}, so the power-up display reads 0,1,2,...
- Message RAM is a register array of MSG_LEN x 5 bits.
  - A write occurs on a rising edge with msg_we_i=1 and msg_addr_i < MSG_LEN.
  - Writes with msg_addr_i >= MSG_LEN are ignored.
  - A written value is visible on outputs no later than the next scan slot of the affected digit.
- Rotation prescaler:
  - Counts while en_i=1 and pause_i=0; otherwise holds its value.
  - On wrap from 2**TICK_W-1 to 0, pos steps once.
  - dir_i=0: pos = (pos == MSG_LEN-1) ? 0 : pos+1.
  - dir_i=1: pos = (pos == 0) ? MSG_LEN-1 : pos-1.
  - dir_i is sampled on the step cycle only. A change mid-period takes effect on the next step without resetting the prescaler.
- Scan prescaler: free-runs regardless of en_i and pause_i. On wrap, the scan index k advances; it wraps from NUM_DIGITS-1 to 0.
- Digit mapping:
  - Digit NUM_DIGITS-1 is leftmost.
  - Digit k shows msg[(pos + NUM_DIGITS-1-k) mod MSG_LEN].
  - The modulo is computed without a divider, using compare-and-subtract (sum < 2*MSG_LEN).
- Outputs are registered: an_o, sseg_o and dp_o change exactly 1 cycle after the scan index changes.
  - When en_i=0: an_o = all 1s, sseg_o = 7'h7F, dp_o = 1.
  - Otherwise: an_o[k] = 0 and all other bits = 1.
- Segment decode:
  - Symbol bit 4 = 1 gives sseg_o = 7'h7F (blank).
  - Otherwise standard hex decode. Examples: 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, A = 7'b0001000, F = 7'b0001110.
- dp_o = 0 on the digit currently showing message index 0 (start-of-message marker); 1 otherwise.
- Simultaneous events:
  - pause_i=1 on the step cycle: no step.
  - Write to the index being displayed in the same cycle as a scan advance: the old value may show for that slot and the new value must show next slot.
  - Step and scan advance in the same cycle: the registered output uses the post-step pos from the following slot onward.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously). Message contents are reinitialised to 0..MSG_LEN-1.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, MSG_LEN=6, TICK_W=4, REFRESH_W=2.
- Reset release, en_i=1, pause_i=1 -> scan visits an_o = 1110, 1101, 1011, 0111, each for 4 cycles, showing digits 3,2,1,0 with sseg 0110000, 0100100, 1111001, 1000000 respectively; dp_o=0 only while an_o=0111.
- pause_i=0, dir_i=0, 16 cycles -> pos_o=1 and leftmost digit shows 1; after 6 steps (96 cycles) pos_o wraps to 0.
- dir_i=1 from pos_o=0 -> after 16 cycles pos_o=5; window reads 5,0,1,2 and dp_o=0 on digit 2.
- Write addr 2 = 5'h0A, then addr 3 = 5'h10 -> segment 0001000 appears for msg index 2, index 3 shows blank 7'h7F; write to addr 7 -> no change anywhere.
- en_i=0 for 40 cycles -> an_o=1111, pos_o constant; en_i=1 resumes rotation with the prescaler continuing from its held value.
- rst_ni pulsed low mid-rotation (pos_o=4) -> an_o=1111 and sseg_o=7'h7F in the same cycle without a clock edge; after release pos_o=0 and message reads 0..5.
